// File: rtl/rf_wb_arbiter_if.sv
// rf_wb_arbiter_if: write-back request bus and registered register-file write port
interface rf_wb_arbiter_if #(
    parameter int NREQ = 4,
    parameter int XLEN = 32
);
    logic [NREQ-1:0]      req_valid;
    logic [NREQ-1:0]      req_ready;
    logic [5*NREQ-1:0]    req_rd;
    logic [XLEN*NREQ-1:0] req_data;
    logic                 wr_en;
    logic [4:0]           wr_addr;
    logic [XLEN-1:0]      wr_data;
    modport master (
        output req_valid, req_rd, req_data,
        input  req_ready, wr_en, wr_addr, wr_data
    );
    modport slave (
        input  req_valid, req_rd, req_data,
        output req_ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// rf_wb_arbiter: shares the register-file write port among write-back sources and tracks outstanding destination writes
module rf_wb_arbiter #(
    parameter int NREQ      = 4,
    parameter int XLEN      = 32,
    parameter int PRIO_MODE = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    rf_wb_arbiter_if.slave      wb,
    input  logic                issue_valid,
    input  logic [4:0]          issue_rd,
    input  logic [4:0]          rs1_num,
    input  logic [4:0]          rs2_num,
    output logic                rs1_busy,
    output logic                rs2_busy,
    output logic [31:0]         pending
);
    localparam int PW = NREQ > 1 ? $clog2(NREQ) : 1;
    logic [PW-1:0]   rr_ptr_q, rr_ptr_d, gnt_idx;
    logic            gnt_any;
    logic [4:0]      gnt_rd;
    logic            wr_en_q, wr_en_d;
    logic [4:0]      wr_addr_q, wr_addr_d;
    logic [XLEN-1:0] wr_data_q, wr_data_d;
    logic [31:0]     pending_q, pending_d;
    int              base;

    // Scan downwards so the requester closest to the search base is assigned last and wins
    always_comb begin
        base    = PRIO_MODE != 0 ? 0 : int'(rr_ptr_q);
        gnt_any = 1'b0;
        gnt_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (wb.req_valid[(base + k) % NREQ]) begin
                gnt_any = 1'b1;
                gnt_idx = PW'((base + k) % NREQ);
            end
        gnt_rd    = wb.req_rd[5*gnt_idx +: 5];
        rr_ptr_d  = (PRIO_MODE == 0 && gnt_any) ? PW'((int'(gnt_idx) + 1) % NREQ) : rr_ptr_q;
        wr_en_d   = gnt_any && gnt_rd != 5'd0;
        wr_addr_d = gnt_any ? gnt_rd : wr_addr_q;
        wr_data_d = gnt_any ? wb.req_data[XLEN*gnt_idx +: XLEN] : wr_data_q;
        // A fresh reservation overrides the retiring write to the same register
        pending_d = (pending_q & ~((wr_en_q ? 32'd1 : 32'd0) << wr_addr_q))
                  | ((issue_valid ? 32'd1 : 32'd0) << issue_rd);
        pending_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            pending_q <= '0;
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            pending_q <= pending_d;
        end
    end

    assign wb.req_ready = NREQ'(gnt_any) << gnt_idx;
    assign wb.wr_en     = wr_en_q;
    assign wb.wr_addr   = wr_addr_q;
    assign wb.wr_data   = wr_data_q;
    assign pending      = pending_q;
    assign rs1_busy     = pending_q[rs1_num];
    assign rs2_busy     = pending_q[rs2_num];
endmodule

// File: doc/rf_wb_arbiter.md
# rf_wb_arbiter

Write-back arbiter and register scoreboard for the RV32I register file. It shares the register file's single write port between four write-back sources: data-memory load, ALU result, LUI immediate and jump return address. It drives one registered write per cycle and tracks which destination registers still have a write outstanding, so the decode stage can stall on read-after-write hazards. It sits between the execute/memory stages and the register file write port.

## Interface
- `NREQ`, 4: number of write-back requesters. Index 0 = load, 1 = ALU, 2 = LUI, 3 = jump.
- `XLEN`, 32: data width.
- `PRIO_MODE`, 0: arbitration policy. 0 = round-robin, 1 = fixed priority with the lowest index winning.

Ports:
- `clk`  in  1: rising-edge clock.
- `reset_n`  in  1: asynchronous, active-low reset.
- `req_valid`  in  NREQ: requester i has a write pending.
- `req_ready`  out  NREQ: one-hot grant; transfer occurs when `req_valid[i] & req_ready[i]`.
- `req_rd`  in  5*NREQ: destination register per requester, packed as `[5i+4:5i]`.
- `req_data`  in  XLEN*NREQ: write data per requester, packed as `[XLEN*i+XLEN-1:XLEN*i]`.
- `wr_en`  out  1: register-file write enable (registered).
- `wr_addr`  out  5: register-file write address (registered).
- `wr_data`  out  XLEN: register-file write data (registered).
- `issue_valid`  in  1: decode issued an instruction that will write `issue_rd`.
- `issue_rd`  in  5: destination register being reserved.
- `rs1_num`, `rs2_num`  in  5 each: source registers under hazard check.
- `rs1_busy`, `rs2_busy`  out  1 each: source register has an outstanding write.
- `pending`  out  32: scoreboard bit vector, for debug.

## Operation
- **Arbitration is combinational.**
  - At most one `req_ready` bit is high per cycle.
  - A bit is only asserted for a requester whose `req_valid` is high.
  - If no requester is valid, `req_ready` = 0.
- **Round-robin (PRIO_MODE=0).**
  - Search starts at pointer `rr_ptr` and proceeds `rr_ptr`, `rr_ptr+1`, … modulo NREQ.
  - On a transfer to index g, `rr_ptr` ← (g+1) mod NREQ. This wraps from NREQ-1 to 0.
  - With no transfer, `rr_ptr` holds.
- **Fixed priority (PRIO_MODE=1).** The lowest valid index wins; `rr_ptr` is unused.
- **Output stage.** On a transfer from g, the next cycle presents `wr_addr` = `req_rd[g]` and `wr_data` = `req_data[g]`.
  - `wr_en` = 1 unless `req_rd[g]` = 0.
  - A write to x0 is accepted and consumed, but `wr_en` stays 0.
- **Scoreboard.** `pending[r]` is set by `issue_valid` with `issue_rd` = r, for r ≠ 0.
  - It is cleared in the cycle the output stage presents `wr_en`=1, `wr_addr`=r.
  - Set and clear of the same r in the same cycle: set wins, because a newer writer is outstanding.
  - `pending[0]` is constant 0.
- **Hazard outputs.** `rsN_busy` = `pending[rsN_num]`, combinational. `rsN_busy` is always 0 for register 0.
- **Reset values.**
  - `wr_en` = 0, `wr_addr` = 0, `wr_data` = 0.
  - `pending` = 0.
  - `rr_ptr` = 0.
  - `req_ready` follows the arbitration rules combinationally.
- **Reset mid-operation.** Any in-flight output-stage write is discarded; no write occurs after `reset_n` falls.

## Timing
- Transfer at edge N. `wr_en`/`wr_addr`/`wr_data` are valid during cycle N+1, and the register file writes at edge N+1.
- Throughput is one write per cycle. Requesters not granted must hold `req_valid`, `req_rd` and `req_data` stable until granted.
- `pending[r]` falls one cycle after the granting transfer, i.e. at the edge where the register file captures the write.
- `issue_valid` at edge N makes `rsN_busy` visible in cycle N+1.
- Requester starvation bound in round-robin mode: NREQ-1 grants to others.
- Reset is asynchronous assert. Deassertion is sampled at the `clk` edge.

## Test plan
- **Reset.** Hold `reset_n`=0 with arbitrary inputs → `wr_en`=0, `wr_addr`=0, `wr_data`=0, `pending`=0. Release → first grant search starts at index 0.
- **Single requester.** ALU only: `req_valid`=4'b0010, rd=5, data=0x0000_0005 → `req_ready`=4'b0010. Next cycle `wr_en`=1, `wr_addr`=5, `wr_data`=5.
- **Round-robin rotation.** All four valid for 5 cycles, PRIO_MODE=0 → grant order 0,1,2,3,0, and `rr_ptr` wraps to 1.
- **Fixed priority.** PRIO_MODE=1, `req_valid`=4'b1010 for 2 cycles then 4'b1000 → grants 1, 1, then 3.
- **Scoreboard.**
  - `issue_valid` with rd=7; next cycle `rs1_num`=7 → `rs1_busy`=1.
  - Jump requester writes rd=7 → `rs1_busy`=0 the cycle after `wr_en`/`wr_addr`=7.
  - Same-cycle reissue of rd=7 → stays busy.
- **x0 and mid-reset.**
  - Load to rd=0 → `req_ready` asserted, `wr_en`=0, `pending` unchanged.
  - Assert `reset_n`=0 in the cycle after a grant → no write, and all outputs return to reset values immediately.
